// File: rtl/pixel_lane_gearbox_if.sv
// Handshake bundle for pixel_lane_gearbox: input beats, output beats, frame pulse and flush.
// The slave modport is the gearbox view; master is the producer/consumer environment view.
interface pixel_lane_gearbox_if #(
  parameter int IN_LANES  = 8,
  parameter int OUT_LANES = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [24*IN_LANES-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [24*OUT_LANES-1:0] out_data;
  logic                    frame_done;
  logic                    flush;

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, frame_done
  );

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, frame_done
  );
endinterface

// File: rtl/pixel_lane_gearbox.sv
// Lane-count gearbox for RGB888 pixel streams over a circular pixel buffer, with frame pulses.
// Optional synchronous buffer clear on `flush` is enabled by defining GEARBOX_FLUSH_EN.
module pixel_lane_gearbox #(
  parameter int IN_LANES     = 8,
  parameter int OUT_LANES    = 2,
  parameter int BUF_PIX      = 32,
  parameter int FRAME_PIXELS = 786432
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  pixel_lane_gearbox_if.slave  bus
);

  localparam int PIX_W = 24;
  localparam int AW    = $clog2(BUF_PIX);
  localparam int CW    = AW + 1;
  localparam int FW    = $clog2(FRAME_PIXELS) + 1;

  localparam logic [CW-1:0] IN_STEP    = CW'(IN_LANES);
  localparam logic [CW-1:0] OUT_STEP   = CW'(OUT_LANES);
  localparam logic [CW-1:0] FULL_MARK  = CW'(BUF_PIX - IN_LANES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_PIXELS - OUT_LANES);

  logic [PIX_W-1:0] pix_q [BUF_PIX];
  logic [PIX_W-1:0] pix_d [BUF_PIX];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [FW-1:0]    out_pix_cnt_q, out_pix_cnt_d;
  logic             frame_done_q, frame_done_d;

  logic flush_hit;
  logic push;
  logic pop;

`ifdef GEARBOX_FLUSH_EN
  assign flush_hit = bus.flush;
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign flush_hit    = 1'b0;
`endif

  // Ready looks only at registered occupancy, never at out_ready.
  assign bus.in_ready   = HRESETn & (count_q <= FULL_MARK) & ~flush_hit;
  assign bus.out_valid  = (count_q >= OUT_STEP);
  assign bus.frame_done = frame_done_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready & ~flush_hit;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pix_d = pix_q;
    if (push) begin
      for (int k = 0; k < IN_LANES; k++) begin
        pix_d[wr_ptr_q + AW'(k)] = bus.in_data[PIX_W*k +: PIX_W];
      end
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    out_pix_cnt_d = out_pix_cnt_q;
    frame_done_d  = 1'b0;
    if (flush_hit) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      out_pix_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(IN_LANES);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(OUT_LANES);
        if (out_pix_cnt_q == FRAME_LAST) begin
          out_pix_cnt_d = '0;
          frame_done_d  = 1'b1;
        end else begin
          out_pix_cnt_d = out_pix_cnt_q + FW'(OUT_LANES);
        end
      end
      count_d = count_q + (push ? IN_STEP : '0) - (pop ? OUT_STEP : '0);
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < OUT_LANES; k++) begin
      bus.out_data[PIX_W*k +: PIX_W] = pix_q[rd_ptr_q + AW'(k)];
    end
  end

  // NOTE: the pixel array is reset as well, so out_data reads as 0 out of reset instead of X.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < BUF_PIX; i++) begin
        pix_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_pix_cnt_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values regardless of statement order.
      pix_q         <= pix_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_pix_cnt_q <= out_pix_cnt_d;
      frame_done_q  <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_pixel_lane_gearbox.sv
// Self-checking bench for pixel_lane_gearbox: an 8->2 instance and a 1->16 instance, each
// compared every cycle against a pixel-queue reference model.
module tb_pixel_lane_gearbox;

  localparam int BUF_PIX = 32;
  localparam int FRAME   = 64;
  localparam int A_IN    = 8;
  localparam int A_OUT   = 2;
  localparam int B_IN    = 1;
  localparam int B_OUT   = 16;
  localparam int A_W     = 24 * A_IN;
  localparam int B_OW    = 24 * B_OUT;
`ifdef GEARBOX_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  pixel_lane_gearbox_if #(.IN_LANES(A_IN), .OUT_LANES(A_OUT)) bus_a ();
  pixel_lane_gearbox_if #(.IN_LANES(B_IN), .OUT_LANES(B_OUT)) bus_b ();

  pixel_lane_gearbox #(.IN_LANES(A_IN), .OUT_LANES(A_OUT), .BUF_PIX(BUF_PIX), .FRAME_PIXELS(FRAME))
    dut_a (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_a.slave));
  pixel_lane_gearbox #(.IN_LANES(B_IN), .OUT_LANES(B_OUT), .BUF_PIX(BUF_PIX), .FRAME_PIXELS(FRAME))
    dut_b (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_b.slave));

  int errors = 0;
  int checks = 0;

  // Reference model: pixels in flight, pixels popped since reset/flush, pending frame pulse.
  logic [23:0] q_a[$];
  logic [23:0] q_b[$];
  int pops_a = 0, pops_b = 0;
  bit fd_exp_a = 1'b0, fd_exp_b = 1'b0;
  int fd_seen_a = 0;

  function automatic logic [23:0] idx_pix(input int i);
    logic [7:0] v;
    v = 8'(i);
    return {v, v, v};
  endfunction

  function automatic logic [A_W-1:0] idx_beat_a(input int base);
    logic [A_W-1:0] r;
    for (int k = 0; k < A_IN; k++) r[24*k +: 24] = idx_pix(base + k);
    return r;
  endfunction

  function automatic logic [A_W-1:0] rand_beat_a();
    logic [A_W-1:0] r;
    for (int k = 0; k < A_IN; k++) r[24*k +: 24] = 24'($urandom());
    return r;
  endfunction

  task automatic step_a(input bit iv, input logic [A_W-1:0] data, input bit ordy,
                        input bit fl, output bit acc);
    bit exp_ready, exp_valid;
    logic [23:0] exp_pix;
    @(negedge HCLK);
    bus_a.in_valid  = iv;
    bus_a.in_data   = data;
    bus_a.out_ready = ordy;
    bus_a.flush     = fl;
    #1;
    exp_ready = ((BUF_PIX - q_a.size()) >= A_IN) && !(fl && FLUSH_ON);
    exp_valid = (q_a.size() >= A_OUT);
    checks++;
    if (bus_a.in_ready !== exp_ready) begin
      errors++;
      $display("FAIL a_in_ready: got %b expected %b (model holds %0d px)", bus_a.in_ready, exp_ready, q_a.size());
    end
    checks++;
    if (bus_a.out_valid !== exp_valid) begin
      errors++;
      $display("FAIL a_out_valid: got %b expected %b (model holds %0d px)", bus_a.out_valid, exp_valid, q_a.size());
    end
    checks++;
    if (bus_a.frame_done !== fd_exp_a) begin
      errors++;
      $display("FAIL a_frame_done: got %b expected %b (pops %0d)", bus_a.frame_done, fd_exp_a, pops_a);
    end
    if (bus_a.frame_done === 1'b1) fd_seen_a++;
    fd_exp_a = 1'b0;
    acc = iv && exp_ready;
    if (fl && FLUSH_ON) begin
      q_a.delete();
      pops_a = 0;
    end else begin
      if (exp_valid && ordy) begin
        for (int k = 0; k < A_OUT; k++) begin
          exp_pix = q_a.pop_front();
          checks++;
          if (bus_a.out_data[24*k +: 24] !== exp_pix) begin
            errors++;
            $display("FAIL a_out_data lane %0d: got %h expected %h", k, bus_a.out_data[24*k +: 24], exp_pix);
          end
        end
        pops_a += A_OUT;
        if (pops_a % FRAME == 0) fd_exp_a = 1'b1;
      end
      if (acc) for (int k = 0; k < A_IN; k++) q_a.push_back(data[24*k +: 24]);
    end
  endtask

  task automatic step_b(input bit iv, input logic [23:0] data, input bit ordy, output bit acc);
    bit exp_ready, exp_valid;
    logic [B_OW-1:0] exp_data;
    @(negedge HCLK);
    bus_b.in_valid  = iv;
    bus_b.in_data   = data;
    bus_b.out_ready = ordy;
    bus_b.flush     = 1'b0;
    #1;
    exp_ready = ((BUF_PIX - q_b.size()) >= B_IN);
    exp_valid = (q_b.size() >= B_OUT);
    checks++;
    if (bus_b.in_ready !== exp_ready) begin
      errors++;
      $display("FAIL b_in_ready: got %b expected %b", bus_b.in_ready, exp_ready);
    end
    checks++;
    if (bus_b.out_valid !== exp_valid) begin
      errors++;
      $display("FAIL b_out_valid: got %b expected %b (model holds %0d px)", bus_b.out_valid, exp_valid, q_b.size());
    end
    checks++;
    if (bus_b.frame_done !== fd_exp_b) begin
      errors++;
      $display("FAIL b_frame_done: got %b expected %b", bus_b.frame_done, fd_exp_b);
    end
    fd_exp_b = 1'b0;
    acc = iv && exp_ready;
    if (exp_valid && ordy) begin
      for (int k = 0; k < B_OUT; k++) exp_data[24*k +: 24] = q_b.pop_front();
      checks++;
      if (bus_b.out_data !== exp_data) begin
        errors++;
        $display("FAIL b_out_data: got %h expected %h", bus_b.out_data, exp_data);
      end
      pops_b += B_OUT;
      if (pops_b % FRAME == 0) fd_exp_b = 1'b1;
    end
    if (acc) q_b.push_back(data);
  endtask

  // Streams npix pixels (indexed or random) through instance A and drains it; returns frame pulses.
  task automatic run_a(input int npix, input bit rnd, output int pulses);
    int sent = 0;
    int cyc = 0;
    int base = fd_seen_a;
    bit acc, iv, ordy;
    logic [A_W-1:0] d;
    while ((sent < npix || q_a.size() != 0) && cyc < 4000) begin
      iv   = (sent < npix) && (!rnd || $urandom_range(0, 1) == 1);
      ordy = !rnd || $urandom_range(0, 1) == 1;
      d    = rnd ? rand_beat_a() : idx_beat_a(sent);
      step_a(iv, d, ordy, 1'b0, acc);
      if (acc) sent += A_IN;
      cyc++;
    end
    step_a(1'b0, '0, 1'b1, 1'b0, acc);
    checks++;
    if (sent != npix || q_a.size() != 0) begin
      errors++;
      $display("FAIL a_run_complete: sent %0d of %0d, %0d px left after %0d cycles", sent, npix, q_a.size(), cyc);
    end
    pulses = fd_seen_a - base;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0; bus_a.flush = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0; bus_b.flush = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    #1;
    checks++;
    if (bus_a.in_ready !== 1'b0 || bus_b.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got a=%b b=%b expected 0", bus_a.in_ready, bus_b.in_ready);
    end
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got a=%b b=%b expected 0", bus_a.out_valid, bus_b.out_valid);
    end
    checks++;
    if (bus_a.frame_done !== 1'b0 || bus_a.out_data !== '0 || bus_b.out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: frame_done=%b a_data=%h b_data=%h expected zero",
               bus_a.frame_done, bus_a.out_data, bus_b.out_data);
    end
    HRESETn = 1'b1;
    #1;
    checks++;
    if (bus_a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready: got %b expected 1", bus_a.in_ready);
    end
  endtask

  task automatic test_ordering();
    int pulses;
    run_a(FRAME, 1'b0, pulses);
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL ordering_frame_done: got %0d pulses expected 1", pulses);
    end
  endtask

  task automatic test_wrap_around();
    int pulses;
    run_a(200, 1'b1, pulses);
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL wrap_frame_done: got %0d pulses expected 3", pulses);
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    int pops = 0;
    bit found = 1'b0;
    bit acc;
    int pulses;
    for (int c = 0; c < 8; c++) begin
      step_a(1'b1, rand_beat_a(), 1'b0, 1'b0, acc);
      if (bus_a.in_ready === 1'b1) accepted++;
    end
    checks++;
    if (accepted != BUF_PIX / A_IN) begin
      errors++;
      $display("FAIL backpressure_accepted: got %0d beats expected %0d", accepted, BUF_PIX / A_IN);
    end
    for (int c = 0; c < 12 && !found; c++) begin
      step_a(1'b0, '0, 1'b1, 1'b0, acc);
      if (bus_a.in_ready === 1'b1) found = 1'b1;
      else pops++;
    end
    checks++;
    if (!found || pops != 4) begin
      errors++;
      $display("FAIL backpressure_release: ready seen=%b after %0d pops expected after 4", found, pops);
    end
    run_a(0, 1'b0, pulses);
  endtask

  task automatic test_reset_mid_frame();
    int sent = 0;
    int cyc = 0;
    int pulses;
    bit acc;
    while (sent < 40 && cyc < 100) begin
      step_a(1'b1, idx_beat_a(sent), 1'b1, 1'b0, acc);
      if (acc) sent += A_IN;
      cyc++;
    end
    #2;
    HRESETn = 1'b0;
    bus_a.in_valid = 1'b0;
    #1;
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b0 || bus_a.out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_frame: out_valid=%b in_ready=%b data=%h expected 0/0/0",
               bus_a.out_valid, bus_a.in_ready, bus_a.out_data);
    end
    q_a.delete(); pops_a = 0; fd_exp_a = 1'b0;
    q_b.delete(); pops_b = 0; fd_exp_b = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    run_a(FRAME, 1'b0, pulses);
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL reset_mid_frame_restart: got %0d pulses expected 1", pulses);
    end
  endtask

  // With the flush feature built in, the buffer empties and the same-cycle beat is lost;
  // without it, flush must have no effect. The model covers both cases.
  task automatic test_flush();
    bit acc;
    int pulses, exp_pulses;
    step_a(1'b1, idx_beat_a(100), 1'b0, 1'b0, acc);
    step_a(1'b1, idx_beat_a(108), 1'b0, 1'b0, acc);
    step_a(1'b0, '0, 1'b1, 1'b0, acc);
    step_a(1'b0, '0, 1'b1, 1'b0, acc);
    step_a(1'b1, idx_beat_a(116), 1'b1, 1'b1, acc);
    step_a(1'b0, '0, 1'b0, 1'b0, acc);
    exp_pulses = (pops_a + q_a.size() + FRAME) / FRAME - pops_a / FRAME;
    run_a(FRAME, 1'b0, pulses);
    checks++;
    if (pulses != exp_pulses) begin
      errors++;
      $display("FAIL flush_frame_done: got %0d pulses expected %0d", pulses, exp_pulses);
    end
  endtask

  task automatic test_reverse_ratio();
    bit acc;
    logic [B_OW-1:0] exp_data;
    for (int i = 0; i < B_OUT; i++) step_b(1'b1, idx_pix(i), 1'b1, acc);
    checks++;
    if (bus_b.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reverse_15_px_valid: got %b expected 0", bus_b.out_valid);
    end
    step_b(1'b0, '0, 1'b1, acc);
    for (int k = 0; k < B_OUT; k++) exp_data[24*k +: 24] = idx_pix(k);
    checks++;
    if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== exp_data) begin
      errors++;
      $display("FAIL reverse_16_px_beat: valid=%b data=%h expected 1 / %h", bus_b.out_valid, bus_b.out_data, exp_data);
    end
    step_b(1'b0, '0, 1'b1, acc);
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_wrap_around();
    test_backpressure();
    test_reset_mid_frame();
    test_flush();
    test_reverse_ratio();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
